// File: rtl/rv32i_types.sv
// Shared RV32I type definitions for the MEM-stage access unit, plus the
// pure request-shaping helpers (fault check, byte mask, lane-replicated data).
package rv32i_types;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } store_funct3_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mau_state_t;

  // Illegal combination, illegal width encoding, or misaligned address.
  function automatic logic mau_fault(input logic       rd,
                                     input logic       wr,
                                     input logic [2:0] f3,
                                     input logic [1:0] lane);
    logic f;
    f = 1'b0;
    if (rd && wr) begin
      f = 1'b1;
    end else if (rd) begin
      case (f3)
        LB, LBU: f = 1'b0;
        LH, LHU: f = lane[0];
        LW:      f = (lane != 2'b00);
        default: f = 1'b1;
      endcase
    end else if (wr) begin
      case (f3)
        SB:      f = 1'b0;
        SH:      f = lane[0];
        SW:      f = (lane != 2'b00);
        default: f = 1'b1;
      endcase
    end
    return f;
  endfunction

  // Loads always enable all four lanes; the cache returns the whole word.
  function automatic logic [3:0] mau_mask(input logic       wr,
                                          input logic [2:0] f3,
                                          input logic [1:0] lane);
    logic [3:0] m;
    m = 4'b1111;
    if (wr) begin
      case (f3)
        SB:      m = 4'b0001 << lane;
        SH:      m = 4'b0011 << lane;
        default: m = 4'b1111;
      endcase
    end
    return m;
  endfunction

  // Replicating the datum across lanes lets the mask alone pick the target bytes.
  function automatic logic [31:0] mau_wdata(input logic        wr,
                                            input logic [2:0]  f3,
                                            input logic [31:0] data);
    logic [31:0] w;
    w = 32'h0;
    if (wr) begin
      case (f3)
        SB:      w = {4{data[7:0]}};
        SH:      w = {2{data[15:0]}};
        default: w = data;
      endcase
    end
    return w;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load extraction: selects the addressed byte/halfword of the
// returned word and sign- or zero-extends it according to the load funct3.
//   word   in  32  word returned by the data cache
//   lane   in  2   byte offset of the access within the word
//   funct3 in  3   load width/signedness encoding
//   data   out 32  extended load result
module load_extend
  import rv32i_types::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h0;
    case (lane)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    // Halfword accesses are only ever at lane 0 or 2 (others fault upstream).
    half_sel = lane[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    data = word;
    case (funct3)
      LB:      data = {{24{byte_sel[7]}}, byte_sel};
      LBU:     data = {24'h0, byte_sel};
      LH:      data = {{16{half_sel[15]}}, half_sel};
      LHU:     data = {16'h0, half_sel};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit. Converts a decoded load/store into a
// registered, word-aligned data-cache request, stalls the pipeline until the
// cache responds, and returns the extended load result.
//   clk, rst                      clock, synchronous active-high reset
//   valid, mem_read, mem_write    live instruction and its access type
//   funct3, addr, store_data      width encoding, byte address, rs2 value
//   dmem_address/read/write/wmask/wdata  registered cache request
//   dmem_rdata, dmem_resp         cache read data and one-cycle completion
//   stall, done, load_data        pipeline freeze, completion pulse, result
//   access_fault                  misaligned or illegal access, no request made
//
// state | meaning
// IDLE  | waiting for a non-faulting access; latches the request on accept
// BUSY  | request strobe held stable until dmem_resp
// DONE  | one-cycle completion; the still-present instruction is not re-accepted
module mem_access_unit
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic [31:0] dmem_address,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [3:0]  dmem_wmask,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic        stall,
  output logic        done,
  output logic [31:0] load_data,
  output logic        access_fault
);

  mau_state_t  state_q, state_d;
  logic [31:0] address_q, address_d;
  logic [1:0]  lane_q, lane_d;
  logic [3:0]  wmask_q, wmask_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [31:0] load_data_q, load_data_d;

  logic        access;
  logic        fault;
  logic [31:0] ext_data;

  assign access = valid & (mem_read | mem_write);
  assign fault  = mau_fault(mem_read, mem_write, funct3, addr[1:0]);

  load_extend u_load_extend (
    .word   (dmem_rdata),
    .lane   (lane_q),
    .funct3 (funct3_q),
    .data   (ext_data)
  );

  always_comb begin
    state_d     = state_q;
    address_d   = address_q;
    lane_d      = lane_q;
    wmask_d     = wmask_q;
    wdata_d     = wdata_q;
    funct3_d    = funct3_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    load_data_d = load_data_q;
    case (state_q)
      IDLE: begin
        if (access && !fault) begin
          address_d = {addr[31:2], 2'b00};
          lane_d    = addr[1:0];
          wmask_d   = mau_mask(mem_write, funct3, addr[1:0]);
          wdata_d   = mau_wdata(mem_write, funct3, store_data);
          funct3_d  = funct3;
          rd_d      = mem_read;
          wr_d      = mem_write;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (dmem_resp) begin
          load_data_d = rd_q ? ext_data : 32'h0;
          rd_d        = 1'b0;
          wr_d        = 1'b0;
          state_d     = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      address_q   <= 32'h0;
      lane_q      <= 2'b00;
      wmask_q     <= 4'h0;
      wdata_q     <= 32'h0;
      funct3_q    <= 3'b000;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      load_data_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      address_q   <= address_d;
      lane_q      <= lane_d;
      wmask_q     <= wmask_d;
      wdata_q     <= wdata_d;
      funct3_q    <= funct3_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      load_data_q <= load_data_d;
    end
  end

  assign dmem_address = address_q;
  assign dmem_read    = rd_q;
  assign dmem_write   = wr_q;
  assign dmem_wmask   = wmask_q;
  assign dmem_wdata   = wdata_q;
  assign load_data    = load_data_q;
  assign done         = (state_q == DONE);
  assign stall        = access & ~fault & (state_q != DONE);
  // Faults are only meaningful when the unit could accept the instruction.
  assign access_fault = access & fault & (state_q == IDLE);

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [31:0] dmem_address;
  logic        dmem_read;
  logic        dmem_write;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic        stall;
  logic        done;
  logic [31:0] load_data;
  logic        access_fault;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk          (clk),
    .rst          (rst),
    .valid        (valid),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .funct3       (funct3),
    .addr         (addr),
    .store_data   (store_data),
    .dmem_address (dmem_address),
    .dmem_read    (dmem_read),
    .dmem_write   (dmem_write),
    .dmem_wmask   (dmem_wmask),
    .dmem_wdata   (dmem_wdata),
    .dmem_rdata   (dmem_rdata),
    .dmem_resp    (dmem_resp),
    .stall        (stall),
    .done         (done),
    .load_data    (load_data),
    .access_fault (access_fault)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model (transaction level) ----------------
  function automatic int m_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic m_fault(input logic rd, input logic wr, input logic [2:0] f3,
                                   input logic [31:0] a);
    int  lane;
    logic legal;
    lane = int'(a[1:0]);
    if (rd && wr) return 1'b1;
    if (rd) legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    else    legal = (f3 inside {3'd0, 3'd1, 3'd2});
    if (!legal) return 1'b1;
    return (lane % m_size(f3)) != 0;
  endfunction

  function automatic logic [3:0] m_mask(input logic wr, input logic [2:0] f3, input logic [31:0] a);
    int s;
    int lane;
    if (!wr) return 4'hF;
    s    = m_size(f3);
    lane = int'(a[1:0]);
    return 4'((((1 << s) - 1) << lane) & 15);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
    int     s;
    longint v;
    longint mult;
    s    = m_size(f3);
    v    = longint'(sd) % (64'sd1 << (8 * s));
    mult = (s == 1) ? 64'sh01010101 : (s == 2) ? 64'sh00010001 : 64'sd1;
    return 32'(v * mult);
  endfunction

  function automatic logic [31:0] m_load(input logic wr, input logic [2:0] f3,
                                         input logic [31:0] a, input logic [31:0] rdat);
    int     s;
    int     lane;
    longint w;
    longint v;
    if (wr) return 32'h0;
    s    = m_size(f3);
    lane = int'(a[1:0]);
    w    = longint'(rdat);
    v    = (w >> (8 * lane)) % (64'sd1 << (8 * s));
    if (!f3[2] && s < 4 && v >= (64'sd1 << (8 * s - 1))) v = v - (64'sd1 << (8 * s));
    return 32'(v);
  endfunction

  // ---------------- one complete access ----------------
  // Presents the instruction in the current cycle; the response arrives after
  // lat BUSY cycles. Returns with valid low in the cycle after DONE.
  task automatic run_txn(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdat,
                         input int lat, input logic drop_valid,
                         input logic e_fault, input logic [3:0] e_mask,
                         input logic [31:0] e_wdata, input logic [31:0] e_load);
    valid = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3; addr = a; store_data = sd;
    dmem_resp = 1'b0; dmem_rdata = $urandom;
    #1;
    chk("c0_done", 32'(done), 32'd0);
    chk("c0_fault", 32'(access_fault), 32'(e_fault));
    chk("c0_stall", 32'(stall), 32'(!e_fault));
    chk("c0_rd", 32'(dmem_read), 32'd0);
    chk("c0_wr", 32'(dmem_write), 32'd0);
    next_cycle();
    if (e_fault) begin
      valid = 1'b0;
      #1;
      chk("flt_no_rd", 32'(dmem_read), 32'd0);
      chk("flt_no_wr", 32'(dmem_write), 32'd0);
      chk("flt_done", 32'(done), 32'd0);
      return;
    end
    for (int c = 1; c <= lat; c++) begin
      valid      = drop_valid ? 1'b0 : 1'b1;
      dmem_resp  = (c == lat);
      dmem_rdata = (c == lat) ? rdat : $urandom;
      #1;
      chk("busy_rd", 32'(dmem_read), 32'(rd));
      chk("busy_wr", 32'(dmem_write), 32'(wr));
      chk("busy_addr", dmem_address, {a[31:2], 2'b00});
      chk("busy_mask", 32'(dmem_wmask), 32'(e_mask));
      if (wr) chk("busy_wdata", dmem_wdata, e_wdata);
      chk("busy_stall", 32'(stall), 32'(valid));
      chk("busy_done", 32'(done), 32'd0);
      chk("busy_fault", 32'(access_fault), 32'd0);
      next_cycle();
    end
    dmem_resp  = 1'b0;
    dmem_rdata = $urandom;
    valid      = 1'b1;
    #1;
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_stall", 32'(stall), 32'd0);
    chk("done_rd", 32'(dmem_read), 32'd0);
    chk("done_wr", 32'(dmem_write), 32'd0);
    chk("done_load", load_data, e_load);
    next_cycle();
    valid = 1'b0;
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] sd;
    logic [31:0] rdat;
    int          lat;
    logic        fault;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic [31:0] load;
  } vec_t;

  vec_t tbl[14];

  initial begin
    logic        rd, wr, dv;
    logic [2:0]  f3;
    logic [31:0] a, sd, rdat;
    int          lat;

    tbl[0]  = '{1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 3, 1'b0, 4'b1111, 32'hDEADBEEF, 32'h0};
    tbl[1]  = '{1'b0, 1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 2, 1'b0, 4'b1000, 32'hA5A5A5A5, 32'h0};
    tbl[2]  = '{1'b1, 1'b0, 3'b000, 32'h102, 32'h0, 32'h0080FF00, 2, 1'b0, 4'b1111, 32'h0, 32'hFFFFFF80};
    tbl[3]  = '{1'b1, 1'b0, 3'b100, 32'h102, 32'h0, 32'h0080FF00, 1, 1'b0, 4'b1111, 32'h0, 32'h00000080};
    tbl[4]  = '{1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h0080FF00, 4, 1'b0, 4'b1111, 32'h0, 32'h00000080};
    tbl[5]  = '{1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 1, 1'b1, 4'b0000, 32'h0, 32'h0};
    tbl[6]  = '{1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 1, 1'b1, 4'b0000, 32'h0, 32'h0};
    tbl[7]  = '{1'b0, 1'b1, 3'b001, 32'h101, 32'h1234, 32'h0, 1, 1'b1, 4'b0000, 32'h0, 32'h0};
    tbl[8]  = '{1'b0, 1'b1, 3'b001, 32'h102, 32'h1234BEEF, 32'h0, 2, 1'b0, 4'b1100, 32'hBEEFBEEF, 32'h0};
    tbl[9]  = '{1'b1, 1'b0, 3'b101, 32'h100, 32'h0, 32'h1234F00D, 1, 1'b0, 4'b1111, 32'h0, 32'h0000F00D};
    tbl[10] = '{1'b1, 1'b0, 3'b001, 32'h100, 32'h0, 32'h1234F00D, 1, 1'b0, 4'b1111, 32'h0, 32'hFFFFF00D};
    tbl[11] = '{1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 32'hCAFEF00D, 3, 1'b0, 4'b1111, 32'h0, 32'hCAFEF00D};
    tbl[12] = '{1'b0, 1'b1, 3'b011, 32'h100, 32'h0, 32'h0, 1, 1'b1, 4'b0000, 32'h0, 32'h0};
    tbl[13] = '{1'b1, 1'b1, 3'b000, 32'h100, 32'h0, 32'h0, 1, 1'b1, 4'b0000, 32'h0, 32'h0};

    rst = 1'b1; valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000;
    addr = 32'h0; store_data = 32'h0; dmem_rdata = 32'h0; dmem_resp = 1'b0;
    repeat (3) next_cycle();
    chk("rst_rd", 32'(dmem_read), 32'd0);
    chk("rst_wr", 32'(dmem_write), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_fault", 32'(access_fault), 32'd0);
    chk("rst_mask", 32'(dmem_wmask), 32'd0);
    chk("rst_addr", dmem_address, 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    chk("rst_load", load_data, 32'd0);
    rst = 1'b0;
    next_cycle();

    // Directed table
    for (int i = 0; i < 14; i++) begin
      run_txn(tbl[i].rd, tbl[i].wr, tbl[i].f3, tbl[i].a, tbl[i].sd, tbl[i].rdat, tbl[i].lat,
              1'b0, tbl[i].fault, tbl[i].mask, tbl[i].wdata, tbl[i].load);
      next_cycle();
    end

    // Back-to-back loads with immediate response; run_txn checks done=0 on entry
    run_txn(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 32'h11112222, 1, 1'b0, 1'b0, 4'hF, 32'h0, 32'h11112222);
    run_txn(1'b1, 1'b0, 3'b000, 32'h201, 32'h0, 32'h0000FE00, 1, 1'b0, 1'b0, 4'hF, 32'h0, 32'hFFFFFFFE);
    #1;
    chk("b2b_single_done", 32'(done), 32'd0);
    next_cycle();

    // Response while idle is ignored
    dmem_resp = 1'b1;
    next_cycle();
    dmem_resp = 1'b0;
    #1;
    chk("idle_resp_done", 32'(done), 32'd0);
    chk("idle_resp_rd", 32'(dmem_read), 32'd0);
    next_cycle();

    // Valid dropping in BUSY does not cancel the request
    run_txn(1'b0, 1'b1, 3'b000, 32'h301, 32'h0000005A, 32'h0, 3, 1'b1, 1'b0, 4'b0010, 32'h5A5A5A5A, 32'h0);
    next_cycle();

    // Reset while BUSY
    valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h400;
    next_cycle();
    #1;
    chk("rbusy_rd", 32'(dmem_read), 32'd1);
    rst = 1'b1; valid = 1'b0;
    next_cycle();
    chk("rbusy_rd_drop", 32'(dmem_read), 32'd0);
    chk("rbusy_stall", 32'(stall), 32'd0);
    rst = 1'b0;
    next_cycle();
    dmem_resp = 1'b1;
    next_cycle();
    dmem_resp = 1'b0;
    #1;
    chk("rbusy_no_done", 32'(done), 32'd0);
    chk("rbusy_no_rd", 32'(dmem_read), 32'd0);
    next_cycle();

    // Randomized traffic against the reference model
    for (int t = 0; t < 200; t++) begin
      int kind;
      kind = $urandom_range(0, 9);
      rd   = (kind < 5) || (kind == 9);
      wr   = (kind >= 5);
      if (kind == 8) begin rd = 1'b0; wr = 1'b0; end
      f3   = 3'($urandom_range(0, 7));
      a    = $urandom;
      sd   = $urandom;
      rdat = $urandom;
      lat  = $urandom_range(1, 4);
      dv   = ($urandom_range(0, 3) == 0);
      if (!rd && !wr) begin
        valid = 1'($urandom_range(0, 1)); mem_read = 1'b0; mem_write = 1'b0;
        funct3 = f3; addr = a; store_data = sd;
        #1;
        chk("rnd_idle_stall", 32'(stall), 32'd0);
        chk("rnd_idle_fault", 32'(access_fault), 32'd0);
        next_cycle();
        valid = 1'b0;
        #1;
        chk("rnd_idle_rd", 32'(dmem_read), 32'd0);
        chk("rnd_idle_wr", 32'(dmem_write), 32'd0);
      end else begin
        run_txn(rd, wr, f3, a, sd, rdat, lat, dv, m_fault(rd, wr, f3, a),
                m_mask(wr, f3, a), m_wdata(f3, sd), m_load(wr, f3, a, rdat));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage data-memory access unit: the consumer of the memory fields of the decoded control word (mem_read, mem_write, funct3). Turns a decoded load/store plus its byte address into a word-aligned, handshaked data-cache request. Builds the lane-shifted byte mask and store data, and stalls the pipeline until the cache responds. Returns the sign- or zero-extended load result for writeback.

## Interface
Parameters:
- none (RV32I, 32-bit data, 4 byte lanes fixed)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- valid  in  1  MEM stage holds a live instruction
- mem_read  in  1  control-word load request
- mem_write  in  1  control-word store request
- funct3  in  3  load_funct3_t / store_funct3_t encoding
- addr  in  32  byte address from ALU
- store_data  in  32  rs2 value, unshifted
- dmem_address  out  32  word-aligned address, {addr[31:2],2'b00}
- dmem_read  out  1  cache read strobe
- dmem_write  out  1  cache write strobe
- dmem_wmask  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_rdata  in  32  cache read data
- dmem_resp  in  1  cache completion, one-cycle pulse
- stall  out  1  freeze pipeline stages up to MEM
- done  out  1  one-cycle pulse: access complete
- load_data  out  32  extended load result, valid while done=1
- access_fault  out  1  one-cycle pulse: misaligned or illegal funct3

## Operation
- Access = valid & (mem_read | mem_write); both set is illegal → fault.
- Byte lane = addr[1:0]. Mask: sb 4'b0001<<lane, sh 4'b0011<<lane, sw 4'b1111; loads drive 4'b1111 on the mask.
- wdata: sb replicates store_data[7:0] ×4; sh replicates [15:0] ×2; sw passes through.
- Fault: halfword with addr[0]=1; word with addr[1:0]≠0; load funct3 ∉ {lb,lh,lw,lbu,lhu}; store funct3 ∉ {sb,sh,sw}. Faulting access issues no request, stall=0, access_fault=1 in that cycle only.
- FSM states IDLE, BUSY, DONE:
  - IDLE: on non-faulting access, latch address, mask, wdata, funct3, and rd/wr; go to BUSY.
  - BUSY: dmem_read/dmem_write held with all request outputs stable; on dmem_resp, latch extended rdata, go to DONE.
  - DONE: done=1; go to IDLE unconditionally. The same instruction is still on the inputs and is not re-accepted.
- Load extension of the latched word at the latched lane: lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word. For stores, load_data=0.
- stall = access & ~fault & (state≠DONE).
- dmem_resp in IDLE or DONE is ignored.

## Timing
- Reset values: state IDLE; dmem_read, dmem_write, stall, done, and access_fault all 0; dmem_wmask 0; dmem_address, dmem_wdata, and load_data 0.
- Request outputs are registered. Access accepted at cycle 0 → strobe asserted from cycle 1.
- Response at cycle N (N≥1) → strobe drops at N+1, done=1 at N+1, stall=0 at N+1. Pipeline stalls N+1 cycles.
- Back-to-back accesses: second accepted in the cycle after DONE; minimum 3 cycles per access.
- rst in BUSY: strobes 0 the next cycle; any later dmem_resp is ignored.
- valid dropping while in BUSY does not cancel an issued request; it completes normally.

## Structure
- rv32i_types gets mau_state_t {IDLE, BUSY, DONE}; reuse load_funct3_t and store_funct3_t.
- Sub-module load_extend: combinational lane select plus sign/zero extension from (word, lane, funct3).

## Test plan
- sw addr=0x100, data=0xDEADBEEF, resp on cycle 3 → dmem_address=0x100, wmask=1111, wdata=0xDEADBEEF; stall cycles 0–3; done at 4.
- sb addr=0x103, data=0x000000A5 → wmask=1000, wdata=0xA5A5A5A5, dmem_write high until resp.
- lb addr=0x102, rdata=0x0080FF00 → load_data=0xFFFFFF80; lbu same → 0x00000080; lh addr=0x102 → 0x00000080.
- lw addr=0x102 → access_fault=1 for one cycle; no strobe; stall=0. Same for funct3=3'b011 load.
- Reset asserted in BUSY with dmem_read=1 → dmem_read=0 next cycle; a resp two cycles later produces no done.
- Two loads back-to-back with immediate resp → each done exactly once; second request issues the cycle after the first done.
